fp32_to_bfp_converter: RTL

- Converts a stream of IEEE-754 FP32 values into block-floating-point (BFP) groups for the MAC array: one shared exponent plus GRPSIZE short sign/magnitude mantissas.
- Sits at the array input; it is the encode side of the BFP-to-FP32 output generator.
- Collects GRPSIZE elements, tracks the maximum exponent, then emits each element right-aligned to that shared exponent.

---
 rtl/fp32_to_bfp_converter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp32_to_bfp_converter.sv
// FP32 -> block-floating-point encoder: collects GRPSIZE elements, then emits them aligned to the group max exponent.
// Optional round-to-nearest-even on the emitted mantissa is selected by defining BFP_ROUND_NEAREST_EN.
module fp32_to_bfp_converter #(
    parameter int GRPSIZE    = 16,
    parameter int BFPEXPSIZE = 8,
    parameter int BFPMANSIZE = 4,
    parameter int CNTW       = $clog2(GRPSIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_fp,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign,
    output logic [BFPMANSIZE-1:0] o_man,
    output logic [BFPEXPSIZE-1:0] o_exp,
    output logic                  o_last
);

    localparam int MW = BFPMANSIZE + 3;   // buffered mantissa: value bits + guard/sticky seeds
    localparam int FT = 23 - (MW - 1);    // fraction tail collapsed into the mantissa LSB
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(GRPSIZE - 1);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [7:0]      max_exp_q, max_exp_d;

    logic            sign_buf [GRPSIZE];
    logic [7:0]      exp_buf  [GRPSIZE];
    logic [MW-1:0]   man_buf  [GRPSIZE];

    logic [7:0]      in_exp;
    logic [MW-1:0]   in_man;
    logic            accept;
    logic            emit_hs;

    // Input classification: denormals flush to zero, Inf/NaN saturate at the top finite exponent.
    always_comb begin
        in_exp = i_fp[30:23];
        in_man = {1'b1, i_fp[22 -: MW-1]} | {{(MW-1){1'b0}}, |i_fp[FT-1:0]};
        if (i_fp[30:23] == 8'd0) begin
            in_exp = 8'd0;
            in_man = '0;
        end else if (i_fp[30:23] == 8'hFF) begin
            in_exp = 8'd254;
            in_man = '1;
        end
    end

    assign accept  = (state_q == COLLECT) && i_valid;
    assign emit_hs = (state_q == EMIT) && i_ready;

    always_ff @(posedge i_clk) begin
        if (accept) begin
            sign_buf[count_q] <= i_fp[31];
            exp_buf[count_q]  <= in_exp;
            man_buf[count_q]  <= in_man;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            max_exp_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_exp_q <= max_exp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_exp_d = max_exp_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (in_exp > max_exp_q) max_exp_d = in_exp;
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (emit_hs) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        count_d   = '0;
                        max_exp_d = 8'd0;
                        state_d   = COLLECT;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    logic [7:0]            shift;
    logic [MW-1:0]         sel_man;
    logic [BFPMANSIZE-1:0] man_res;

    assign sel_man = man_buf[count_q];
    assign shift   = max_exp_q - exp_buf[count_q];

`ifdef BFP_ROUND_NEAREST_EN
    logic [2*MW-1:0]       ext;
    logic [BFPMANSIZE-1:0] top;
    logic                  guard;
    logic                  sticky;

    always_comb begin
        ext     = {sel_man, {MW{1'b0}}} >> shift;
        top     = ext[2*MW-1 -: BFPMANSIZE];
        guard   = ext[2*MW-1-BFPMANSIZE];
        sticky  = |ext[2*MW-2-BFPMANSIZE:0];
        man_res = top;
        // Carry out of an all-ones mantissa saturates instead of bumping the shared exponent.
        if (guard && (sticky || top[0]) && (top != '1)) man_res = top + 1'b1;
    end
`else
    always_comb begin
        man_res = '0;
        if (shift < 8'(MW)) man_res = BFPMANSIZE'(sel_man >> (32'(shift) + 32'd3));
    end
`endif

    assign o_ready = (state_q == COLLECT);
    assign o_valid = (state_q == EMIT);
    assign o_sign  = o_valid ? sign_buf[count_q] : 1'b0;
    assign o_man   = o_valid ? man_res : '0;
    assign o_exp   = o_valid ? BFPEXPSIZE'(max_exp_q) : '0;
    assign o_last  = o_valid && (count_q == LAST_IDX);

endmodule
